// File: rtl/regfile_bist_if.sv
// Register-file port bundle: one synchronous write port and two asynchronous read ports.
interface regfile_bist_if;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;

    // The BIST side drives addresses and write data and observes read data.
    modport master (
        output we3, wa3, wd3, ra1, ra2,
        input  rd1, rd2
    );

    // The register file side.
    modport slave (
        input  we3, wa3, wd3, ra1, ra2,
        output rd1, rd2
    );
endinterface

// File: rtl/regfile_bist.sv
// Two-pass address-keyed march over a 2R/1W register file, with mismatch counting
// and capture of the first failing address, port and observed data.
module regfile_bist #(
    parameter int unsigned NREGS    = 32,
    parameter logic [31:0] PATTERN  = 32'hA5C3_0F96,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [7:0]     err_count,
    output logic [4:0]     fail_addr,
    output logic           fail_port,
    output logic [31:0]    fail_data,
    regfile_bist_if.master rf
);

    typedef enum logic [2:0] {StIdle, StWr0, StRd0, StWr1, StRd1, StDone} state_e;

    localparam logic [4:0] LastIdx = 5'(NREGS - 1);

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  err_q;
    logic [4:0]  fail_addr_q;
    logic        fail_port_q;
    logic [31:0] fail_data_q;

    logic        phase;
    logic        in_rd;
    logic        idle_like;
    logic [4:0]  mirror;
    logic        mis1, mis2;
    logic [8:0]  err_sum;

    // Data written in pass p; the hardwired-zero override is deliberately absent here.
    function automatic logic [31:0] pat_val(input logic [4:0] a, input logic p);
        logic [31:0] base;
        base = PATTERN ^ {27'b0, a};
        return p ? ~base : base;
    endfunction

    // Value a healthy register file returns, honouring a hardwired r0.
    function automatic logic [31:0] exp_val(input logic [4:0] a, input logic p);
        if (ZERO_REG && (a == 5'd0)) begin
            return 32'd0;
        end
        return pat_val(a, p);
    endfunction

    assign phase     = (state_q == StWr1) || (state_q == StRd1);
    assign in_rd     = (state_q == StRd0) || (state_q == StRd1);
    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign mirror    = LastIdx - idx_q;
    assign mis1      = in_rd && (rf.rd1 != exp_val(idx_q, phase));
    assign mis2      = in_rd && (rf.rd2 != exp_val(mirror, phase));
    assign err_sum   = {1'b0, err_q} + {8'd0, mis1} + {8'd0, mis2};

    // State and march index register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: each march state sweeps idx over all registers, then hands over.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWr0;
                    idx_d   = 5'd0;
                end
            end
            StWr0, StRd0, StWr1, StRd1: begin
                if (idx_q == LastIdx) begin
                    idx_d = 5'd0;
                    unique case (state_q)
                        StWr0:   state_d = StRd0;
                        StRd0:   state_d = StWr1;
                        StWr1:   state_d = StRd1;
                        default: state_d = StDone;
                    endcase
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = 5'd0;
            end
        endcase
    end

    // Outputs decoded from the registered state, so they change only on clock edges.
    always_comb begin
        rf.we3 = 1'b0;
        rf.wa3 = 5'd0;
        rf.wd3 = 32'd0;
        rf.ra1 = 5'd0;
        rf.ra2 = 5'd0;
        busy   = 1'b0;
        done   = 1'b0;
        unique case (state_q)
            StWr0, StWr1: begin
                busy   = 1'b1;
                rf.we3 = 1'b1;
                rf.wa3 = idx_q;
                rf.wd3 = pat_val(idx_q, phase);
            end
            StRd0, StRd1: begin
                busy   = 1'b1;
                rf.ra1 = idx_q;
                rf.ra2 = mirror;
            end
            StDone:  done = 1'b1;
            default: ;
        endcase
        pass = done && (err_q == 8'd0);
    end

    // Result accounting; a zero count doubles as "no failure captured yet".
    always_ff @(posedge clk) begin
        if (reset || (idle_like && start)) begin
            err_q       <= 8'd0;
            fail_addr_q <= 5'd0;
            fail_port_q <= 1'b0;
            fail_data_q <= 32'd0;
        end else if (in_rd) begin
            err_q <= err_sum[8] ? 8'hFF : err_sum[7:0];
            if ((err_q == 8'd0) && (mis1 || mis2)) begin
                fail_addr_q <= mis1 ? idx_q : mirror;
                fail_port_q <= ~mis1;
                fail_data_q <= mis1 ? rf.rd1 : rf.rd2;
            end
        end
    end

    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    assign fail_port = fail_port_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench: faulty register-file model plus a pass-level reference of
// what the BIST should report for each fault scenario.
module tb_regfile_bist;

    localparam int          N       = 32;
    localparam logic [31:0] PAT     = 32'hA5C3_0F96;

    // Register-file fault scenarios
    localparam int MIdeal = 0;
    localparam int MStuck = 1;
    localparam int MR0Wr  = 2;
    localparam int MRd2Z  = 3;
    localparam int MAll   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass, fail_port;
    logic [7:0]  err_count;
    logic [4:0]  fail_addr;
    logic [31:0] fail_data;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_cnt = 0;

    int mode = MIdeal;
    int stuck_a = 5;
    int stuck_b = 3;

    logic [31:0] mem [N];

    regfile_bist_if rf_bus ();

    regfile_bist #(.NREGS(N), .PATTERN(PAT), .ZERO_REG(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_addr (fail_addr),
        .fail_port (fail_port),
        .fail_data (fail_data),
        .rf        (rf_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 32'd0;
    end

    // Synchronous write port of the model
    always @(posedge clk) begin
        if (rf_bus.we3) mem[rf_bus.wa3] <= rf_bus.wd3;
    end

    // Asynchronous read ports of the model, with the selected fault applied
    always_comb begin
        logic [31:0] v1, v2;
        v1 = mem[rf_bus.ra1];
        v2 = mem[rf_bus.ra2];
        if (mode != MR0Wr) begin
            if (rf_bus.ra1 == 5'd0) v1 = 32'd0;
            if (rf_bus.ra2 == 5'd0) v2 = 32'd0;
        end
        if (mode == MStuck) begin
            if (int'(rf_bus.ra1) == stuck_a) v1[stuck_b] = 1'b1;
            if (int'(rf_bus.ra2) == stuck_a) v2[stuck_b] = 1'b1;
        end
        if (mode == MRd2Z) v2 = 32'd0;
        if (mode == MAll) begin
            v1 = ~v1;
            v2 = ~v2;
        end
        rf_bus.rd1 = v1;
        rf_bus.rd2 = v2;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat_of(input int a, input int p);
        logic [31:0] b;
        b = PAT ^ 32'(a);
        return (p != 0) ? ~b : b;
    endfunction

    // What the faulty model returns on a port after pass p has written everything
    function automatic logic [31:0] model_read(input int a, input int p, input int port);
        logic [31:0] v;
        v = (a == 0 && mode != MR0Wr) ? 32'd0 : pat_of(a, p);
        if (mode == MStuck && a == stuck_a) v[stuck_b] = 1'b1;
        if (mode == MRd2Z && port == 1) v = 32'd0;
        if (mode == MAll) v = ~v;
        return v;
    endfunction

    // Reference result of a complete march against the current fault scenario
    task automatic ref_run(output int err, output int f_addr, output int f_port,
                           output logic [31:0] f_data);
        bit first;
        first  = 1'b1;
        err    = 0;
        f_addr = 0;
        f_port = 0;
        f_data = 32'd0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < N; i++) begin
                int          addr [2];
                logic [31:0] got;
                addr[0] = i;
                addr[1] = N - 1 - i;
                for (int port = 0; port < 2; port++) begin
                    logic [31:0] want;
                    want = (addr[port] == 0) ? 32'd0 : pat_of(addr[port], p);
                    got  = model_read(addr[port], p, port);
                    if (got != want) begin
                        err = (err < 255) ? err + 1 : 255;
                        if (first) begin
                            first  = 1'b0;
                            f_addr = addr[port];
                            f_port = port;
                            f_data = got;
                        end
                    end
                end
            end
        end
    endtask

    // One full test: start pulse, optional spurious start mid-run, then result checks
    task automatic run_bist(input string name, input int idle, input int spur);
        int          k, cyc, busy_cyc, e_err, e_addr, e_port;
        logic [31:0] e_data;
        ref_run(e_err, e_addr, e_port, e_data);
        repeat (idle) @(negedge clk);
        start = 1'b1;
        k = edge_cnt + 1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        while (!done && cyc < 4 * N + 20) begin
            if (busy) busy_cyc++;
            start = (cyc == spur);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_val({name, ":done"}, 32'(done), 32'd1);
        check_val({name, ":done_edge"}, 32'(edge_cnt), 32'(k + 4 * N));
        check_val({name, ":busy_cycles"}, 32'(busy_cyc), 32'(4 * N));
        check_val({name, ":busy_end"}, 32'(busy), 32'd0);
        check_val({name, ":pass"}, 32'(pass), (e_err == 0) ? 32'd1 : 32'd0);
        check_val({name, ":err_count"}, 32'(err_count), 32'(e_err));
        check_val({name, ":fail_addr"}, 32'(fail_addr), 32'(e_addr));
        check_val({name, ":fail_port"}, 32'(fail_port), 32'(e_port));
        check_val({name, ":fail_data"}, fail_data, e_data);
        @(negedge clk);
        check_val({name, ":done_sticky"}, 32'(done), 32'd1);
    endtask

    initial begin
        int ra_ok;
        // Reset held through edge 1; sample at the following falling edge
        @(negedge clk);
        check_val("rst:busy", 32'(busy), 32'd0);
        check_val("rst:done", 32'(done), 32'd0);
        check_val("rst:pass", 32'(pass), 32'd0);
        check_val("rst:err", 32'(err_count), 32'd0);
        check_val("rst:we3", 32'(rf_bus.we3), 32'd0);
        check_val("rst:wa3", 32'(rf_bus.wa3), 32'd0);
        check_val("rst:wd3", rf_bus.wd3, 32'd0);
        check_val("rst:ra", {rf_bus.ra1, rf_bus.ra2}, 32'd0);
        reset = 1'b0;

        // Ideal model, start sampled at edge 2: done lands on edge 130
        mode = MIdeal;
        run_bist("ideal", 0, -1);

        // Fixed stuck-at: reg 5 bit 3 reads as 1
        mode = MStuck;
        stuck_a = 5;
        stuck_b = 3;
        run_bist("stuck5b3", 2, -1);
        check_val("stuck5b3:data_formula", fail_data, pat_of(5, 0) | 32'd8);

        mode = MR0Wr;
        run_bist("r0_writable", 1, -1);
        check_val("r0_writable:data_is_pat", fail_data, PAT);

        mode = MRd2Z;
        run_bist("rd2_zero", 3, -1);

        mode = MAll;
        run_bist("all_faulty", 0, -1);

        // Randomized scenarios with spurious start pulses while busy
        for (int t = 0; t < 6; t++) begin
            mode = int'($urandom_range(0, 4));
            stuck_a = int'($urandom_range(0, N - 1));
            stuck_b = int'($urandom_range(0, 31));
            run_bist($sformatf("rand%0d_m%0d", t, mode), int'($urandom_range(0, 4)),
                     int'($urandom_range(1, 4 * N - 3)));
        end

        // Spurious start 38 edges in, reset 58 edges in, then a clean run
        mode = MIdeal;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (37) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("midrun:still_busy", 32'(busy), 32'd1);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrun:we3", 32'(rf_bus.we3), 32'd0);
        check_val("midrun:busy", 32'(busy), 32'd0);
        check_val("midrun:done", 32'(done), 32'd0);
        check_val("midrun:err", 32'(err_count), 32'd0);
        ra_ok = (rf_bus.ra1 == 5'd0 && rf_bus.ra2 == 5'd0) ? 1 : 0;
        check_val("midrun:ra_zero", 32'(ra_ok), 32'd1);
        reset = 1'b0;
        run_bist("after_reset", 1, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global safety net so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1);
    end

endmodule
